multichannel_chunk_processor: RTL and testbench
===============================================

// Module: multichannel_chunk_processor
// PURPOSE
//  Chunk-driven sequencer between interleaved input/output sample buffers and an external streaming filter core.
//  On each chunk_pulse, waits START_DELAY cycles, then walks the whole input buffer.
//  Each sample goes through the filter via an rfd/nd/rdy handshake; results are written to the same output-buffer index.
//  Multi-channel successor of the single-channel chunk processor: it adds channel tagging, a done pulse, an overrun flag and an optional bypass.
// PARAMETERS
//  SAMPLE_SIZE       24   sample width in bits (filter in/out and buffers)
//  NUM_CHANNELS      2    interleaved channels; buffer index i belongs to channel i % NUM_CHANNELS
//  IO_BUFF_SIZE      64   samples per buffer; must be a multiple of NUM_CHANNELS
//  IO_BUFF_PTR_BITS  $clog2(IO_BUFF_SIZE)   buffer pointer width
//  CH_BITS           (NUM_CHANNELS>1) ? $clog2(NUM_CHANNELS) : 1   channel index width
//  START_DELAY       64   idle cycles between chunk acceptance and first filter feed (0 = none)
// PORTS
//  clk                      in   1            single clock, all logic on posedge
//  rst                      in   1            synchronous, active-high reset
//  chunk_pulse              in   1            1-cycle pulse: new input chunk available
//  input_buff_ptr           out  PTR_BITS     input-buffer read index (combinational read; data valid same cycle)
//  input_buff_sample        in   SAMPLE_SIZE  sample at input_buff_ptr
//  output_buff_ptr          out  PTR_BITS     output-buffer write index (equals input_buff_ptr)
//  output_buff_sample       out  SAMPLE_SIZE  data to write
//  output_buff_write_pulse  out  1            write strobe, 1 cycle per sample
//  flt_rfd / flt_rdy        in   1            filter ready-for-data / output-ready
//  flt_nd                   out  1            new-data strobe to filter
//  flt_din                  out  SAMPLE_SIZE  filter input (= input_buff_sample)
//  flt_dout                 in   SAMPLE_SIZE  filter result
//  flt_chan                 out  CH_BITS      channel of sample in flight
//  busy                     out  1            high in any state except IDLE
//  chunk_done               out  1            registered 1-cycle pulse the cycle after the last write
//  chunk_overrun            out  1            sticky: chunk_pulse arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE; ptr, chan, delay counter = 0.
//   All strobes/flags (flt_nd, output_buff_write_pulse, chunk_done, chunk_overrun, busy) = 0.
//   Reset mid-chunk aborts immediately; no further writes are issued.
//  FSM states: IDLE -> DELAY -> WAIT_RFD -> WAIT_RDY -> (WAIT_RFD | IDLE).
//  IDLE: chunk_pulse=1 -> DELAY, or -> WAIT_RFD directly if START_DELAY==0. Ptr and chan are already 0.
//  DELAY: counter runs 0..START_DELAY-1, one step per cycle; at START_DELAY-1 -> WAIT_RFD, counter cleared.
//   First possible flt_nd is therefore cycle 1+START_DELAY after the chunk_pulse cycle.
//  WAIT_RFD: flt_nd is combinational = flt_rfd, high for exactly the one cycle that moves to WAIT_RDY.
//  WAIT_RDY: flt_nd=0. When flt_rdy=1:
//   - output_buff_write_pulse=1 and output_buff_sample=flt_dout, same cycle.
//   - ptr increments; chan increments, wrapping NUM_CHANNELS-1 -> 0.
//   - If ptr==IO_BUFF_SIZE-1: ptr=0, chan=0, -> IDLE, chunk_done=1 next cycle. Otherwise -> WAIT_RFD.
//   - flt_rdy outside WAIT_RDY is ignored (no write).
//  flt_chan = chan register; constant 0 when NUM_CHANNELS==1.
//  chunk_pulse while busy: ignored for sequencing, sets chunk_overrun (stays 1 until rst).
//   On the cycle chunk_done is high the FSM is IDLE, so a chunk_pulse then is accepted normally.
//  No arithmetic on sample data; widths pass through unchanged.
// CONFIGURATION
//  CHUNK_PROC_BYPASS_EN defined: adds input port `bypass` (1 bit), latched on chunk acceptance in IDLE.
//   Latched 1: FSM runs IDLE -> DELAY -> BYPASS. BYPASS writes input_buff_sample to the same index every cycle, one sample/cycle.
//   In BYPASS, flt_nd never asserts; flt_chan still tracks chan; last index -> IDLE + chunk_done.
//  Not defined: `bypass` port and BYPASS state are absent; every sample goes through the filter.
// TESTING (NUM_CHANNELS=2, IO_BUFF_SIZE=8, START_DELAY=4, SAMPLE_SIZE=24; model: rfd=1, rdy 3 cycles after nd, dout=din+1)
//  1 Input buf = 0x000010..0x000017, chunk_pulse @cycle 0
//    -> first flt_nd @cycle 5; 8 writes, output[i]=0x000011+i; flt_chan 0,1,0,1,...
//    -> chunk_done once, 1 cycle after 8th write; busy then 0.
//  2 Model holds rfd=0 for 10 cycles mid-chunk -> no flt_nd and no writes during the stall; results still correct, exactly 8 writes.
//  3 Second chunk_pulse 3 cycles after the first -> chunk_overrun=1 and stays 1.
//    -> Chunk completes with 8 writes; no restart.
//  4 rst asserted after the 3rd write -> all outputs 0 next cycle; no further writes.
//    -> A new chunk_pulse then runs a full 8-write chunk from ptr 0.
//  5 START_DELAY=0 build: chunk_pulse @0 -> flt_nd @1; spurious flt_rdy while IDLE -> no write.
//  6 CHUNK_PROC_BYPASS_EN, bypass=1 -> writes on 8 consecutive cycles starting cycle 5.
//    -> output[i]=input[i]; flt_nd never 1; chunk_done 1 cycle after last write.

Source files
------------

// File: rtl/multichannel_chunk_processor_if.sv
// Buffer-side and filter-core-side signals of the multichannel chunk processor.
// master = the chunk processor; slave = the sample buffers plus the filter core.
interface multichannel_chunk_processor_if #(
    parameter int SAMPLE_SIZE = 24,
    parameter int PTR_BITS    = 6,
    parameter int CH_BITS     = 1
);
    logic [PTR_BITS-1:0]    input_buff_ptr;
    logic [SAMPLE_SIZE-1:0] input_buff_sample;
    logic [PTR_BITS-1:0]    output_buff_ptr;
    logic [SAMPLE_SIZE-1:0] output_buff_sample;
    logic                   output_buff_write_pulse;
    logic                   flt_rfd;
    logic                   flt_rdy;
    logic                   flt_nd;
    logic [SAMPLE_SIZE-1:0] flt_din;
    logic [SAMPLE_SIZE-1:0] flt_dout;
    logic [CH_BITS-1:0]     flt_chan;

    modport master (
        output input_buff_ptr,
        input  input_buff_sample,
        output output_buff_ptr,
        output output_buff_sample,
        output output_buff_write_pulse,
        input  flt_rfd,
        input  flt_rdy,
        output flt_nd,
        output flt_din,
        input  flt_dout,
        output flt_chan
    );

    modport slave (
        input  input_buff_ptr,
        output input_buff_sample,
        input  output_buff_ptr,
        input  output_buff_sample,
        input  output_buff_write_pulse,
        output flt_rfd,
        output flt_rdy,
        input  flt_nd,
        input  flt_din,
        output flt_dout,
        input  flt_chan
    );
endinterface

// File: rtl/multichannel_chunk_processor.sv
// Purpose: per chunk_pulse, streams the interleaved input buffer through a filter core into the output buffer.
// Latency: first flt_nd START_DELAY+1 cycles after chunk_pulse; chunk_done one cycle after the last write.
// Backpressure: stalls on flt_rfd/flt_rdy; chunk_pulse while busy is dropped and sets chunk_overrun.
// Optional CHUNK_PROC_BYPASS_EN adds a `bypass` input that copies input to output without the filter.
module multichannel_chunk_processor #(
    parameter int SAMPLE_SIZE      = 24,
    parameter int NUM_CHANNELS     = 2,
    parameter int IO_BUFF_SIZE     = 64,
    parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
    parameter int CH_BITS          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int START_DELAY      = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic chunk_pulse,
`ifdef CHUNK_PROC_BYPASS_EN
    input  logic bypass,
`endif
    multichannel_chunk_processor_if.master io,
    output logic busy,
    output logic chunk_done,
    output logic chunk_overrun
);

    localparam int DLY_BITS = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DLY_BITS-1:0] DLY_LAST =
        (START_DELAY > 0) ? DLY_BITS'(START_DELAY - 1) : '0;
    localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
    localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(NUM_CHANNELS - 1);

    typedef logic [SAMPLE_SIZE-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WAIT_RFD,
        ST_WAIT_RDY
`ifdef CHUNK_PROC_BYPASS_EN
        , ST_BYPASS
`endif
    } state_t;

    state_t                      state_q, state_d;
    state_t                      run_from_idle, run_from_delay;
    logic [IO_BUFF_PTR_BITS-1:0] ptr_q;
    logic [CH_BITS-1:0]          chan_q;
    logic [DLY_BITS-1:0]         dly_q;
    logic                        done_q;
    logic                        overrun_q;
    logic                        advance;
    logic                        dly_run;
    logic                        nd;
    logic                        last_idx;
    sample_t                     wr_sample;

    assign last_idx = (ptr_q == PTR_LAST);

    // The working state after start-up: bypass is sampled live on acceptance, then held.
`ifdef CHUNK_PROC_BYPASS_EN
    logic bypass_q;
    assign run_from_idle  = bypass   ? ST_BYPASS : ST_WAIT_RFD;
    assign run_from_delay = bypass_q ? ST_BYPASS : ST_WAIT_RFD;
`else
    assign run_from_idle  = ST_WAIT_RFD;
    assign run_from_delay = ST_WAIT_RFD;
`endif

    always_comb begin
        state_d   = state_q;
        advance   = 1'b0;
        dly_run   = 1'b0;
        nd        = 1'b0;
        wr_sample = io.flt_dout;
        case (state_q)
            ST_IDLE: begin
                if (chunk_pulse) begin
                    state_d = (START_DELAY == 0) ? run_from_idle : ST_DELAY;
                end
            end
            ST_DELAY: begin
                dly_run = 1'b1;
                if (dly_q == DLY_LAST) begin
                    state_d = run_from_delay;
                end
            end
            ST_WAIT_RFD: begin
                nd = io.flt_rfd;
                if (io.flt_rfd) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (io.flt_rdy) begin
                    advance = 1'b1;
                    state_d = last_idx ? ST_IDLE : ST_WAIT_RFD;
                end
            end
`ifdef CHUNK_PROC_BYPASS_EN
            ST_BYPASS: begin
                advance   = 1'b1;
                wr_sample = io.input_buff_sample;
                if (last_idx) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            chan_q    <= '0;
            dly_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef CHUNK_PROC_BYPASS_EN
            bypass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= advance && last_idx;
            if (chunk_pulse && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (dly_run) begin
                dly_q <= (dly_q == DLY_LAST) ? '0 : dly_q + 1'b1;
            end
            if (advance) begin
                if (last_idx) begin
                    ptr_q  <= '0;
                    chan_q <= '0;
                end else begin
                    ptr_q  <= ptr_q + 1'b1;
                    chan_q <= (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
                end
            end
`ifdef CHUNK_PROC_BYPASS_EN
            if ((state_q == ST_IDLE) && chunk_pulse) begin
                bypass_q <= bypass;
            end
`endif
        end
    end

    assign io.input_buff_ptr          = ptr_q;
    assign io.output_buff_ptr         = ptr_q;
    assign io.output_buff_sample      = wr_sample;
    assign io.output_buff_write_pulse = advance;
    assign io.flt_nd                  = nd;
    assign io.flt_din                 = io.input_buff_sample;
    assign io.flt_chan                = chan_q;
    assign busy                       = (state_q != ST_IDLE);
    assign chunk_done                 = done_q;
    assign chunk_overrun              = overrun_q;

endmodule

// File: tb/tb_multichannel_chunk_processor.sv
// Randomized bench for multichannel_chunk_processor: two instances (START_DELAY 4 and 0)
// driven by a behavioural filter model; results compared with output[i] = input[i] + 1.
module tb_multichannel_chunk_processor;
    localparam int SS   = 24;
    localparam int NC   = 2;
    localparam int BS   = 8;
    localparam int PB   = 3;
    localparam int CB   = 1;
    localparam int SD_A = 4;
    localparam int SD_B = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multichannel_chunk_processor_if #(.SAMPLE_SIZE(SS), .PTR_BITS(PB), .CH_BITS(CB)) ifa ();
    multichannel_chunk_processor_if #(.SAMPLE_SIZE(SS), .PTR_BITS(PB), .CH_BITS(CB)) ifb ();

    logic          pulse, sel, rfd, rdy;
    logic [SS-1:0] dout;
    logic [SS-1:0] mem_in [BS];
    logic          pulse_a, pulse_b;
    logic          busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;
    bit            byp_mode;

    int checks   = 0;
    int failures = 0;

    assign pulse_a = pulse & ~sel;
    assign pulse_b = pulse & sel;

    assign ifa.input_buff_sample = mem_in[ifa.input_buff_ptr];
    assign ifb.input_buff_sample = mem_in[ifb.input_buff_ptr];
    assign ifa.flt_rfd  = rfd;
    assign ifb.flt_rfd  = rfd;
    assign ifa.flt_rdy  = rdy;
    assign ifb.flt_rdy  = rdy;
    assign ifa.flt_dout = dout;
    assign ifb.flt_dout = dout;

`ifdef CHUNK_PROC_BYPASS_EN
    logic bypass;
    assign bypass = byp_mode;
`endif

    multichannel_chunk_processor #(
        .SAMPLE_SIZE(SS), .NUM_CHANNELS(NC), .IO_BUFF_SIZE(BS), .START_DELAY(SD_A)
    ) dut_a (
        .clk(clk), .rst(rst), .chunk_pulse(pulse_a),
`ifdef CHUNK_PROC_BYPASS_EN
        .bypass(bypass),
`endif
        .io(ifa.master), .busy(busy_a), .chunk_done(done_a), .chunk_overrun(ovr_a)
    );

    multichannel_chunk_processor #(
        .SAMPLE_SIZE(SS), .NUM_CHANNELS(NC), .IO_BUFF_SIZE(BS), .START_DELAY(SD_B)
    ) dut_b (
        .clk(clk), .rst(rst), .chunk_pulse(pulse_b),
`ifdef CHUNK_PROC_BYPASS_EN
        .bypass(bypass),
`endif
        .io(ifb.master), .busy(busy_b), .chunk_done(done_b), .chunk_overrun(ovr_b)
    );

    // Observed outputs of whichever instance is under test.
    logic          o_wr, o_nd, o_busy, o_done, o_ovr;
    logic [PB-1:0] o_ptr, o_optr;
    logic [CB-1:0] o_chan;
    logic [SS-1:0] o_smp, o_din;

    always_comb begin
        o_wr = ifa.output_buff_write_pulse; o_nd = ifa.flt_nd; o_busy = busy_a;
        o_done = done_a; o_ovr = ovr_a; o_ptr = ifa.input_buff_ptr;
        o_optr = ifa.output_buff_ptr; o_chan = ifa.flt_chan;
        o_smp = ifa.output_buff_sample; o_din = ifa.flt_din;
        if (sel) begin
            o_wr = ifb.output_buff_write_pulse; o_nd = ifb.flt_nd; o_busy = busy_b;
            o_done = done_b; o_ovr = ovr_b; o_ptr = ifb.input_buff_ptr;
            o_optr = ifb.output_buff_ptr; o_chan = ifb.flt_chan;
            o_smp = ifb.output_buff_sample; o_din = ifb.flt_din;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One chunk on the selected instance; cycle 0 is the chunk_pulse cycle.
    task automatic run_chunk(input bit use_b, input bit fixed_pat, input bit do_stall,
                             input int ovr_at, input bit do_rst, input bit spurious,
                             input bit byp, input int exp_ovr);
        logic [SS-1:0] out_got [BS];
        logic [SS-1:0] pend_din;
        logic [SS-1:0] exp_v;
        int sd, cyc, writes, first_nd, first_wr, last_wr, done_cnt, done_cyc;
        int nd_cnt, bad_nd, chan_err, ptr_err, stall_left, stall_nd, stall_wr;
        int pend_cnt, pre_wr, post_wr;
        bit stall_done, stalled_now;

        sd = use_b ? SD_B : SD_A;
        writes = 0; first_nd = -1; first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
        nd_cnt = 0; bad_nd = 0; chan_err = 0; ptr_err = 0; stall_left = 0; stall_nd = 0;
        stall_wr = 0; pend_cnt = 0; pre_wr = 0; post_wr = 0; stall_done = 0;
        pend_din = '0;
        for (int i = 0; i < BS; i++) begin
            out_got[i] = '0;
            mem_in[i] = fixed_pat ? SS'(32'h10 + i) : SS'($urandom);
        end
        if (!fixed_pat && ($urandom_range(0, 1) == 1)) mem_in[BS-1] = '1;

        @(negedge clk);
        sel = use_b; byp_mode = byp; rdy = 1'b0; pulse = 1'b0;
        if (spurious) begin
            repeat (3) begin
                @(negedge clk);
                rdy = 1'b1; dout = SS'($urandom);
                #1;
                if (o_wr) pre_wr++;
            end
            chk("idle_rdy_no_write", pre_wr, 0);
        end

        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            pulse = (cyc == 0) || (cyc == ovr_at);
            rdy = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rdy = 1'b1;
                    dout = pend_din + 1'b1;
                end
            end
            if (do_stall && !stall_done && writes == 3) begin
                stall_left = 10;
                stall_done = 1;
            end
            stalled_now = (stall_left > 0);
            if (stalled_now) begin
                rfd = 1'b0;
                stall_left--;
            end else begin
                rfd = (first_nd < 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            if (do_rst && writes == 3) begin
                rst = 1'b1;
                rfd = 1'b0;
            end
            #1;
            if (o_nd) begin
                nd_cnt++;
                if (!rfd) bad_nd++;
                if (stalled_now) stall_nd++;
                if (first_nd < 0) first_nd = cyc;
                pend_din = o_din;
                pend_cnt = $urandom_range(1, 4);
            end
            if (o_wr) begin
                if (stalled_now) stall_wr++;
                if (int'(o_ptr) != writes || o_optr != o_ptr) ptr_err++;
                if (int'(o_chan) != writes % NC) chan_err++;
                out_got[o_ptr] = o_smp;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                writes++;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rst) begin
                @(negedge clk);
                rst = 1'b0; rfd = 1'b1; pulse = 1'b0;
                #1;
                chk("rst_busy", int'(o_busy), 0);
                chk("rst_write", int'(o_wr), 0);
                chk("rst_nd", int'(o_nd), 0);
                chk("rst_done", int'(o_done), 0);
                chk("rst_overrun", int'(o_ovr), 0);
                chk("rst_ptr", int'(o_ptr), 0);
                repeat (10) begin
                    @(negedge clk);
                    rdy = ($urandom_range(0, 1) == 1);
                    #1;
                    if (o_wr) post_wr++;
                end
                rdy = 1'b0;
                chk("no_write_after_rst", post_wr, 0);
                return;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 4) break;
            cyc++;
        end
        pulse = 1'b0; rdy = 1'b0;

        chk("done_count", done_cnt, 1);
        chk("write_count", writes, BS);
        for (int i = 0; i < BS; i++) begin
            exp_v = byp ? mem_in[i] : mem_in[i] + 1'b1;
            chk($sformatf("out[%0d]", i), int'(out_got[i]), int'(exp_v));
        end
        chk("done_after_last_write", done_cyc, last_wr + 1);
        chk("ptr_order_err", ptr_err, 0);
        chk("chan_seq_err", chan_err, 0);
        if (byp) begin
            chk("bypass_nd_count", nd_cnt, 0);
            chk("bypass_first_write", first_wr, 1 + sd);
            chk("bypass_last_write", last_wr, sd + BS);
        end else begin
            chk("first_nd_cycle", first_nd, 1 + sd);
            chk("nd_count", nd_cnt, BS);
            chk("nd_without_rfd", bad_nd, 0);
        end
        if (do_stall) begin
            chk("stall_nd", stall_nd, 0);
            chk("stall_write", stall_wr, 0);
        end
        chk("busy_after_chunk", int'(o_busy), 0);
        chk("overrun_flag", int'(o_ovr), exp_ovr);
    endtask

    initial begin
        rst = 1'b1; pulse = 1'b0; sel = 1'b0; rfd = 1'b1; rdy = 1'b0; dout = '0; byp_mode = 0;
        for (int i = 0; i < BS; i++) mem_in[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_overrun", int'(o_ovr), 0);
        chk("reset_write", int'(o_wr), 0);
        chk("reset_nd", int'(o_nd), 0);
        chk("reset_ptr", int'(o_ptr), 0);
        chk("reset_chan", int'(o_chan), 0);

        //        use_b fixed stall ovr_at rst spur byp exp_ovr
        run_chunk(0,    1,    0,    -1,    0,  0,   0,  0);
        run_chunk(0,    0,    1,    -1,    0,  0,   0,  0);
        run_chunk(0,    0,    0,     3,    0,  0,   0,  1);
        run_chunk(0,    0,    0,    -1,    1,  0,   0,  0);
        run_chunk(0,    0,    0,    -1,    0,  0,   0,  0);
        run_chunk(1,    0,    0,    -1,    0,  1,   0,  0);
        for (int k = 0; k < 4; k++) begin
            run_chunk(k[0], 0, ($urandom_range(0, 1) == 1), -1, 0, 0, 0, 0);
        end
`ifdef CHUNK_PROC_BYPASS_EN
        run_chunk(0,    0,    0,    -1,    0,  0,   1,  0);
        run_chunk(1,    0,    0,    -1,    0,  0,   1,  0);
        run_chunk(0,    0,    0,    -1,    0,  0,   0,  0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
